// File: rtl/dm_sched.sv
// Data-memory scheduler: round-robin write-burst arbiter for four requesters
// plus an independent read sequencer for instruction and shift reads.
module dm_sched #(
    parameter int LEN_W  = 8,
    parameter int INST_W = 24
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           wr_req,
    input  logic [4*LEN_W-1:0]   wr_len,
    output logic [3:0]           wr_gnt,
    output logic                 wea,
    output logic                 web,
    output logic                 wec,
    output logic                 wed,
    output logic                 wr_done,
    input  logic                 rd_valid,
    output logic                 rd_ready,
    input  logic                 rd_shift,
    input  logic [INST_W-1:0]    rd_inst,
    input  logic [LEN_W-1:0]     rd_len,
    output logic                 inst_v,
    output logic [INST_W-1:0]    inst,
    output logic                 shift_v,
    output logic                 rden,
    output logic                 busy
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_BURST,
        W_GAP
    } w_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_SHIFT,
        R_DRAIN
    } r_state_e;

    w_state_e           w_state_q, w_state_d;
    logic [LEN_W-1:0]   w_cnt_q, w_cnt_d;
    logic [1:0]         w_idx_q, w_idx_d;
    logic [1:0]         w_ptr_q, w_ptr_d;

    r_state_e           r_state_q, r_state_d;
    logic [LEN_W-1:0]   r_cnt_q, r_cnt_d;
    logic [1:0]         tail_q, tail_d;
    logic               inst_v_q, inst_v_d;
    logic [INST_W-1:0]  inst_q, inst_d;
    logic               init_q, init_d;

    logic               arb_hit;
    logic [1:0]         arb_idx;
    logic [1:0]         cand;
    logic [LEN_W-1:0]   arb_len;
    logic               w_stb;
    logic [3:0]         strb;
    logic               accept;

    // Search from the pointer upward; the lowest offset wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = w_ptr_q;
        cand    = w_ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = w_ptr_q + 2'(k);
            if (wr_req[cand]) begin
                arb_hit = 1'b1;
                arb_idx = cand;
            end
        end
        arb_len = wr_len[int'(arb_idx)*LEN_W +: LEN_W];
    end

    assign w_stb   = (w_state_q == W_BURST) && (w_cnt_q != '0);
    assign wr_gnt  = (w_state_q == W_BURST) ? (4'd1 << w_idx_q) : 4'd0;
    assign strb    = w_stb ? wr_gnt : 4'd0;
    assign wea     = strb[0];
    assign web     = strb[1];
    assign wec     = strb[2];
    assign wed     = strb[3];
    assign wr_done = w_stb && (w_cnt_q == LEN_W'(1));

    // The gap cycle doubles as an arbitration slot, so back-to-back
    // bursts are separated by exactly one all-low cycle.
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_ptr_d   = w_ptr_q;
        unique case (w_state_q)
            W_IDLE, W_GAP: begin
                w_state_d = W_IDLE;
                if (arb_hit) begin
                    w_state_d = W_BURST;
                    w_idx_d   = arb_idx;
                    w_ptr_d   = arb_idx + 2'd1;
                    w_cnt_d   = arb_len;
                end
            end
            W_BURST: begin
                if (w_cnt_q == '0) begin
                    w_state_d = W_IDLE;
                end else begin
                    w_cnt_d = w_cnt_q - LEN_W'(1);
                    if (w_cnt_q == LEN_W'(1)) begin
                        w_state_d = W_GAP;
                    end
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    assign rd_ready = init_q && (r_state_q == R_IDLE);
    assign accept   = rd_valid && rd_ready;
    assign shift_v  = (r_state_q == R_SHIFT);
    assign inst_v   = inst_v_q;
    assign inst     = inst_q;
    assign rden     = inst_v_q || shift_v || (tail_q != 2'd0);

    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        inst_v_d  = 1'b0;
        inst_d    = inst_q;
        init_d    = 1'b1;
        tail_d    = 2'd0;
        if (inst_v_q || shift_v) begin
            tail_d = 2'd2;
        end else if (tail_q != 2'd0) begin
            tail_d = tail_q - 2'd1;
        end
        unique case (r_state_q)
            R_IDLE: begin
                if (accept) begin
                    if (!rd_shift) begin
                        inst_v_d = 1'b1;
                        inst_d   = rd_inst;
                    end else if (rd_len != '0) begin
                        r_state_d = R_SHIFT;
                        r_cnt_d   = rd_len;
                    end
                end
            end
            R_SHIFT: begin
                r_cnt_d = r_cnt_q - LEN_W'(1);
                if (r_cnt_q == LEN_W'(1)) begin
                    r_state_d = R_DRAIN;
                    r_cnt_d   = LEN_W'(1);
                end
            end
            R_DRAIN: begin
                if (r_cnt_q == '0) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_cnt_d = r_cnt_q - LEN_W'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_idx_q   <= 2'd0;
            w_ptr_q   <= 2'd0;
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            tail_q    <= 2'd0;
            inst_v_q  <= 1'b0;
            inst_q    <= '0;
            init_q    <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_ptr_q   <= w_ptr_d;
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            tail_q    <= tail_d;
            inst_v_q  <= inst_v_d;
            inst_q    <= inst_d;
            init_q    <= init_d;
        end
    end

    assign busy = (w_state_q != W_IDLE) || (r_state_q != R_IDLE)
                || inst_v_q || rden;

endmodule

// File: tb/tb_dm_sched.sv
// Scoreboard bench for dm_sched: stimulus queues expected write beats,
// read beats and rden run lengths; a negedge monitor pops and compares.
module tb_dm_sched;

    localparam int LEN_W  = 8;
    localparam int INST_W = 24;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [3:0]         wr_req = 4'd0;
    logic [4*LEN_W-1:0] wr_len = '0;
    logic [3:0]         wr_gnt;
    logic               wea, web, wec, wed, wr_done;
    logic               rd_valid = 1'b0;
    logic               rd_ready;
    logic               rd_shift = 1'b0;
    logic [INST_W-1:0]  rd_inst = '0;
    logic [LEN_W-1:0]   rd_len = '0;
    logic               inst_v;
    logic [INST_W-1:0]  inst;
    logic               shift_v, rden, busy;

    always #5 clk = ~clk;

    dm_sched #(.LEN_W(LEN_W), .INST_W(INST_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_len(wr_len), .wr_gnt(wr_gnt),
        .wea(wea), .web(web), .wec(wec), .wed(wed), .wr_done(wr_done),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_shift(rd_shift),
        .rd_inst(rd_inst), .rd_len(rd_len),
        .inst_v(inst_v), .inst(inst), .shift_v(shift_v),
        .rden(rden), .busy(busy)
    );

    typedef struct {
        logic [3:0] gnt;
        logic [3:0] stb;
        logic       done;
        int         gap;
    } wexp_t;

    typedef struct {
        logic              iv;
        logic [INST_W-1:0] ins;
        logic              sv;
    } rexp_t;

    wexp_t wq[$];
    rexp_t rq[$];
    int    rdq[$];

    int errors = 0;
    int checks = 0;
    int low_run = 0;
    int rden_run = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push_w(input logic [3:0] g, input logic [3:0] s,
                          input logic d, input int gap);
        wexp_t e;
        e.gnt = g; e.stb = s; e.done = d; e.gap = gap;
        wq.push_back(e);
    endtask

    task automatic push_r(input logic iv, input logic [INST_W-1:0] ins,
                          input logic sv);
        rexp_t e;
        e.iv = iv; e.ins = ins; e.sv = sv;
        rq.push_back(e);
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!wr_done && n < 50);
        chk(nm, 32'(wr_done), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        wr_req = 4'd0;
        rd_valid = 1'b0;
        @(negedge clk);
        chk("rst_out", {wr_gnt, wea, web, wec, wed, wr_done, inst_v,
                        shift_v, rden, busy, rd_ready}, 32'd0);
        chk("rst_inst", 32'(inst), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(rd_ready), 32'd1);
    endtask

    always @(negedge clk) begin
        logic [3:0] s;
        wexp_t we;
        rexp_t re;
        s = {wed, wec, web, wea};
        chk("stb_onehot", 32'($countones(s) <= 1), 32'd1);
        if (wr_gnt != 4'd0) begin
            if (wq.size() == 0) begin
                chk("wr_unexpected", {wr_gnt, s}, 32'd0);
            end else begin
                we = wq.pop_front();
                chk("wr_beat", {wr_gnt, s, wr_done},
                    {we.gnt, we.stb, we.done});
                if (we.gap >= 0) chk("wr_gap", low_run, we.gap);
            end
            low_run = 0;
        end else begin
            low_run++;
            if (s != 4'd0 || wr_done) chk("wr_idle", {s, wr_done}, 32'd0);
        end
        if (inst_v || shift_v) begin
            if (rq.size() == 0) begin
                chk("rd_unexpected", {inst_v, shift_v}, 32'd0);
            end else begin
                re = rq.pop_front();
                chk("rd_beat", {inst_v, inst, shift_v},
                    {re.iv, re.ins, re.sv});
            end
        end
        if (rden) begin
            rden_run++;
        end else if (rden_run > 0) begin
            if (rdq.size() == 0) chk("rden_unexpected", rden_run, 0);
            else chk("rden_len", rden_run, rdq.pop_front());
            rden_run = 0;
        end
    end

    initial begin
        int n;
        do_reset();

        // Single LOAD burst of 3, then one gap cycle, then idle.
        wr_len[0 +: LEN_W] = 8'd3;
        wr_req = 4'b0001;
        push_w(4'b0001, 4'b0001, 1'b0, -1);
        push_w(4'b0001, 4'b0001, 1'b0, -1);
        push_w(4'b0001, 4'b0001, 1'b1, -1);
        wait_done("done_load3");
        wr_req = 4'd0;
        @(negedge clk);
        chk("gap_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("idle_after_gap", 32'(busy), 32'd0);

        // All four requesting with len 1: strict rotation.
        do_reset();
        wr_len = {8'd1, 8'd1, 8'd1, 8'd1};
        wr_req = 4'b1111;
        push_w(4'b0001, 4'b0001, 1'b1, -1);
        push_w(4'b0010, 4'b0010, 1'b1, 1);
        push_w(4'b0100, 4'b0100, 1'b1, 1);
        push_w(4'b1000, 4'b1000, 1'b1, 1);
        push_w(4'b0001, 4'b0001, 1'b1, 1);
        for (int i = 0; i < 5; i++) wait_done("done_rr");
        wr_req = 4'd0;
        @(negedge clk);
        @(negedge clk);
        chk("rr_idle", 32'(busy), 32'd0);

        // Zero-length TX grant: one gnt cycle, no gap.
        wr_len[2*LEN_W +: LEN_W] = 8'd0;
        wr_req = 4'b0100;
        push_w(4'b0100, 4'b0000, 1'b0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_gnt == 4'd0 && n < 20);
        chk("zero_gnt_seen", 32'(wr_gnt), 32'b0100);
        wr_req = 4'd0;
        @(negedge clk);
        chk("zero_no_gap", 32'(busy), 32'd0);

        // Back-to-back instruction reads.
        rd_valid = 1'b1;
        rd_shift = 1'b0;
        rd_inst = 24'h030201;
        chk("inst_ready", 32'(rd_ready), 32'd1);
        push_r(1'b1, 24'h030201, 1'b0);
        push_r(1'b1, 24'h060504, 1'b0);
        push_r(1'b1, 24'h090807, 1'b0);
        rdq.push_back(5);
        @(negedge clk);
        rd_inst = 24'h060504;
        @(negedge clk);
        rd_inst = 24'h090807;
        @(negedge clk);
        rd_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("inst_hold", {inst_v, inst}, {1'b0, 24'h090807});

        // Shift read of 4 concurrent with a LOAD burst of 5.
        wr_len[0 +: LEN_W] = 8'd5;
        wr_req = 4'b0001;
        rd_valid = 1'b1;
        rd_shift = 1'b1;
        rd_len = 8'd4;
        chk("shift_ready", 32'(rd_ready), 32'd1);
        for (int i = 0; i < 5; i++)
            push_w(4'b0001, 4'b0001, 1'(i == 4), -1);
        for (int i = 0; i < 4; i++) push_r(1'b0, 24'h090807, 1'b1);
        rdq.push_back(6);
        @(negedge clk);
        rd_valid = 1'b0;
        n = 0;
        while (!rd_ready && n < 20) begin
            n++;
            if (wr_done) wr_req = 4'd0;
            @(negedge clk);
        end
        chk("shift_ready_low", n, 6);
        repeat (4) @(negedge clk);
        chk("shift_idle", 32'(busy), 32'd0);

        // Reset in the 2nd cycle of a WB burst of 6.
        wr_len[3*LEN_W +: LEN_W] = 8'd6;
        wr_req = 4'b1000;
        push_w(4'b1000, 4'b1000, 1'b0, -1);
        push_w(4'b1000, 4'b1000, 1'b0, -1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wr_gnt == 4'd0 && n < 20);
        chk("wb_started", 32'(wed), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        wr_req = 4'd0;
        @(negedge clk);
        chk("wb_abort", {wed, wr_done, wr_gnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(rd_ready), 32'd1);
        wr_len = {8'd1, 8'd0, 8'd0, 8'd1};
        wr_req = 4'b1001;
        push_w(4'b0001, 4'b0001, 1'b1, -1);
        push_w(4'b1000, 4'b1000, 1'b1, 1);
        wait_done("done_after_rst_a");
        wait_done("done_after_rst_b");
        wr_req = 4'd0;

        repeat (10) @(negedge clk);
        chk("wq_empty", wq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("rdq_empty", rdq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
